cond_unit: RTL and testbench
============================

// Module: cond_unit
// PURPOSE
//  Consumer side of the execute-stage ALU flag bus {N,Z,C,V,Q}. Holds the
//  architectural NZCV flags and the sticky Q flag. Evaluates the 4-bit ARM
//  condition field of the instruction in E against the held flags. Gates
//  PCSrc/RegWrite/MemWrite into registered M-stage controls.
//  Sits between the ALU and the E->M pipeline register of the datapath.
// PARAMETERS
//  RESET_NZCV  4'b0000  NZCV value loaded on reset
//  RESET_Q     1'b0     Q value loaded on reset
// PORTS
//  clk          in   1  clock, rising edge
//  reset_n      in   1  asynchronous, active-low reset
//  valid_e      in   1  E stage holds a real instruction
//  stall_e      in   1  E stage held this cycle
//  flush_e      in   1  E-stage instruction killed this cycle
//  cond_e       in   4  instruction condition field [31:28]
//  alu_flags    in   5  {N,Z,C,V,Q} from ALU, same cycle
//  flag_write_e in   2  [1]: update N,Z  [0]: update C,V
//  q_write_e    in   1  instruction is QADD/QSUB (may set Q)
//  q_clr        in   1  clear sticky Q (MSR-style write)
//  pcs_e        in   1  instruction writes PC
//  reg_write_e  in   1  instruction writes register file
//  mem_write_e  in   1  instruction writes memory
//  cond_ex      out  1  combinational: condition passed for E instruction
//  pcsrc_m      out  1  registered pcs_e & fire
//  reg_write_m  out  1  registered reg_write_e & fire
//  mem_write_m  out  1  registered mem_write_e & fire
//  flags        out  5  architectural {N,Z,C,V,Q}
// BEHAVIOUR
//  - Reset (async, reset_n=0): flags={RESET_NZCV,RESET_Q}. pcsrc_m, reg_write_m
//    and mem_write_m are 0. Reset mid-instruction discards that instruction.
//  - cond_ex is decoded from registered flags, never from alu_flags:
//    0 EQ Z | 1 NE !Z | 2 CS C | 3 CC !C | 4 MI N | 5 PL !N | 6 VS V | 7 VC !V
//    8 HI C&!Z | 9 LS !C|Z | A GE N==V | B LT N!=V | C GT !Z&(N==V)
//    D LE Z|(N!=V) | E AL 1 | F 1 (unconditional space)
//  - fire = valid_e & ~stall_e & ~flush_e & cond_ex.
//  - On each clk edge:
//    - If fire & flag_write_e[1]: N,Z <= alu_flags[4:3].
//    - If fire & flag_write_e[0]: C,V <= alu_flags[2:1].
//    - Q update: Q <= (Q & ~q_clr) | (fire & q_write_e & alu_flags[0]).
//      Q is sticky: no ALU result clears it. When a set and q_clr occur in
//      the same cycle, the set wins.
//    - M controls <= fire ? {pcs_e,reg_write_e,mem_write_e} : 3'b000.
//      A stall or flush inserts a bubble. No control is held across a stall.
//  - Latency: flags are visible on the cycle after the write. A back-to-back
//    dependent instruction sees the new flags, with no extra bypass.
//  - Failed condition: no flag, Q or control side effect. The instruction is
//    a bubble in M.
//  - cond_ex is driven even when valid_e=0. Consumers must qualify it.
// TESTING
//  - Reset: assert reset_n=0 mid-stream -> flags=5'b00000 and all *_m=0
//    asynchronously. They hold until the first fire after release.
//  - CMP flags: fire with flag_write_e=2'b11, alu_flags=5'b01100 -> next cycle
//    flags=5'b01100. cond_e=0000 (EQ) gives cond_ex=1. cond_e=0001 gives 0.
//  - Conditional kill: flags Z=0, cond_e=0000, reg_write_e=1, flag_write_e=11,
//    alu_flags=5'b10000 -> cond_ex=0, reg_write_m=0, flags unchanged.
//  - Sticky Q: QADD fire with alu_flags[0]=1 -> Q=1. A later QADD with
//    alu_flags[0]=0 leaves Q=1. q_clr=1 alone -> Q=0 next cycle. q_clr=1 with
//    a Q set in the same cycle -> Q=1.
//  - Stall/flush: flag_write_e=11 with stall_e=1, or with flush_e=1 ->
//    flags unchanged and reg_write_m=0. Same instruction un-stalled -> update.
//  - Full sweep: for all 16 cond_e codes x 16 NZCV values, compare cond_ex
//    against the decode table above (256 checks).

Source files
------------

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - ARM condition evaluation, NZCV/sticky-Q flag holding and M-stage control gating
// Conditions are decoded only from the held flags; a newly written flag value is visible one cycle later.
module cond_unit #(
  parameter logic [3:0] RESET_NZCV = 4'b0000,
  parameter logic       RESET_Q    = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid_e,
  input  logic       stall_e,
  input  logic       flush_e,
  input  logic [3:0] cond_e,
  input  logic [4:0] alu_flags,
  input  logic [1:0] flag_write_e,
  input  logic       q_write_e,
  input  logic       q_clr,
  input  logic       pcs_e,
  input  logic       reg_write_e,
  input  logic       mem_write_e,
  output logic       cond_ex,
  output logic       pcsrc_m,
  output logic       reg_write_m,
  output logic       mem_write_m,
  output logic [4:0] flags
);

  logic [3:0] nzcv_q, nzcv_d;
  logic       q_q, q_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic       fire;
  logic       n, z, c, v;

  assign n = nzcv_q[3];
  assign z = nzcv_q[2];
  assign c = nzcv_q[1];
  assign v = nzcv_q[0];

  always_comb begin
    cond_ex = 1'b1;
    case (cond_e)
      4'h0:    cond_ex = z;
      4'h1:    cond_ex = ~z;
      4'h2:    cond_ex = c;
      4'h3:    cond_ex = ~c;
      4'h4:    cond_ex = n;
      4'h5:    cond_ex = ~n;
      4'h6:    cond_ex = v;
      4'h7:    cond_ex = ~v;
      4'h8:    cond_ex = c & ~z;
      4'h9:    cond_ex = ~c | z;
      4'hA:    cond_ex = (n == v);
      4'hB:    cond_ex = (n != v);
      4'hC:    cond_ex = ~z & (n == v);
      4'hD:    cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

  assign fire = valid_e & ~stall_e & ~flush_e & cond_ex;

  always_comb begin
    nzcv_d = nzcv_q;
    if (fire && flag_write_e[1]) nzcv_d[3:2] = alu_flags[4:3];
    if (fire && flag_write_e[0]) nzcv_d[1:0] = alu_flags[2:1];
    // Set term is OR'd after the clear so a same-cycle saturation keeps Q high.
    q_d    = (q_q & ~q_clr) | (fire & q_write_e & alu_flags[0]);
    ctrl_d = fire ? {pcs_e, reg_write_e, mem_write_e} : 3'b000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nzcv_q <= RESET_NZCV;
      q_q    <= RESET_Q;
      ctrl_q <= 3'b000;
    end else begin
      nzcv_q <= nzcv_d;
      q_q    <= q_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign flags       = {nzcv_q, q_q};
  assign pcsrc_m     = ctrl_q[2];
  assign reg_write_m = ctrl_q[1];
  assign mem_write_m = ctrl_q[0];

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - table-driven self-checking bench for cond_unit
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       valid_e, stall_e, flush_e;
  logic [3:0] cond_e;
  logic [4:0] alu_flags;
  logic [1:0] flag_write_e;
  logic       q_write_e, q_clr, pcs_e, reg_write_e, mem_write_e;
  logic       cond_ex, pcsrc_m, reg_write_m, mem_write_m;
  logic [4:0] flags;

  int errors = 0;
  int checks = 0;

  cond_unit dut (
    .clk(clk), .reset_n(reset_n), .valid_e(valid_e), .stall_e(stall_e),
    .flush_e(flush_e), .cond_e(cond_e), .alu_flags(alu_flags),
    .flag_write_e(flag_write_e), .q_write_e(q_write_e), .q_clr(q_clr),
    .pcs_e(pcs_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .cond_ex(cond_ex), .pcsrc_m(pcsrc_m), .reg_write_m(reg_write_m),
    .mem_write_m(mem_write_m), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid, stall, flush;
    logic [3:0] cond;
    logic [4:0] alu;
    logic [1:0] fw;
    logic       qw, qclr, pcs, rw, mw;
    logic       exp_cx;
    logic [4:0] exp_flags;
    logic [2:0] exp_m;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    valid_e = t.valid; stall_e = t.stall; flush_e = t.flush;
    cond_e = t.cond; alu_flags = t.alu; flag_write_e = t.fw;
    q_write_e = t.qw; q_clr = t.qclr; pcs_e = t.pcs;
    reg_write_e = t.rw; mem_write_e = t.mw;
  endtask

  task automatic idle();
    valid_e = 0; stall_e = 0; flush_e = 0; cond_e = 4'h0; alu_flags = 5'b0;
    flag_write_e = 2'b00; q_write_e = 0; q_clr = 0; pcs_e = 0;
    reg_write_e = 0; mem_write_e = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (c)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !fc || fz;
      4'hA: return fn == fv;
      4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return fz || (fn != fv);
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    //          v s f cond  alu       fw    qw qc pc rw mw  cx flags     m
    vecs[0]  = '{1,0,0,4'hE,5'b01100,2'b11,0,0,0,1,0, 1,5'b01100,3'b010};
    vecs[1]  = '{1,0,0,4'h0,5'b00000,2'b00,0,0,1,1,0, 1,5'b01100,3'b110};
    vecs[2]  = '{1,0,0,4'h1,5'b00000,2'b00,0,0,0,1,0, 0,5'b01100,3'b000};
    vecs[3]  = '{1,0,0,4'hE,5'b10000,2'b11,0,0,0,0,0, 1,5'b10000,3'b000};
    vecs[4]  = '{1,0,0,4'h0,5'b01110,2'b11,0,0,0,1,0, 0,5'b10000,3'b000};
    vecs[5]  = '{1,0,0,4'hE,5'b00001,2'b00,1,0,0,1,0, 1,5'b10001,3'b010};
    vecs[6]  = '{1,0,0,4'hE,5'b00000,2'b00,1,0,0,1,0, 1,5'b10001,3'b010};
    vecs[7]  = '{0,0,0,4'hE,5'b00000,2'b00,0,1,0,0,0, 1,5'b10000,3'b000};
    vecs[8]  = '{1,0,0,4'hE,5'b00001,2'b00,1,1,0,0,0, 1,5'b10001,3'b000};
    vecs[9]  = '{1,1,0,4'hE,5'b01010,2'b11,0,0,0,1,0, 1,5'b10001,3'b000};
    vecs[10] = '{1,0,1,4'hE,5'b01010,2'b11,0,0,0,1,0, 1,5'b10001,3'b000};
    vecs[11] = '{1,0,0,4'hE,5'b01010,2'b11,0,0,0,1,0, 1,5'b01011,3'b010};
    vecs[12] = '{1,0,0,4'hE,5'b10100,2'b10,0,0,0,0,1, 1,5'b10011,3'b001};
    vecs[13] = '{1,0,0,4'hE,5'b00100,2'b01,0,0,0,0,0, 1,5'b10101,3'b000};
    vecs[14] = '{1,0,0,4'hA,5'b01110,2'b11,0,0,0,1,0, 0,5'b10101,3'b000};
    vecs[15] = '{1,0,0,4'hB,5'b00000,2'b00,0,0,1,0,0, 1,5'b10101,3'b100};
    vecs[16] = '{0,0,0,4'h0,5'b00000,2'b00,0,1,0,0,0, 0,5'b10100,3'b000};
    vecs[17] = '{1,0,0,4'hA,5'b00001,2'b00,1,0,0,0,0, 0,5'b10100,3'b000};
    vecs[18] = '{1,0,0,4'h8,5'b00000,2'b11,0,0,0,1,1, 1,5'b00000,3'b011};
    vecs[19] = '{1,0,0,4'h9,5'b11110,2'b00,0,0,0,1,0, 1,5'b00000,3'b010};

    idle();
    reset_n = 1'b0;
    #2;
    check("reset_flags", 32'(flags), 32'h0);
    check("reset_m", 32'({pcsrc_m, reg_write_m, mem_write_m}), 32'h0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("post_reset_flags", 32'(flags), 32'h0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_cond_ex", i), 32'(cond_ex), 32'(vecs[i].exp_cx));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].exp_flags));
      check($sformatf("v%0d_m", i), 32'({pcsrc_m, reg_write_m, mem_write_m}), 32'(vecs[i].exp_m));
    end

    // Mid-stream asynchronous reset with an instruction in flight
    drive('{1,0,0,4'hE,5'b11111,2'b11,1,0,1,1,1, 1,5'b11111,3'b111});
    step();
    check("preload_flags", 32'(flags), 32'h1F);
    check("preload_m", 32'({pcsrc_m, reg_write_m, mem_write_m}), 32'h7);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_flags", 32'(flags), 32'h0);
    check("async_reset_m", 32'({pcsrc_m, reg_write_m, mem_write_m}), 32'h0);
    step();
    check("reset_hold_flags", 32'(flags), 32'h0);
    check("reset_hold_m", 32'({pcsrc_m, reg_write_m, mem_write_m}), 32'h0);
    idle();
    reset_n = 1'b1;
    step();
    step();
    check("release_flags", 32'(flags), 32'h0);
    check("release_m", 32'({pcsrc_m, reg_write_m, mem_write_m}), 32'h0);

    // Full condition sweep over every NZCV value
    for (int f = 0; f < 16; f++) begin
      idle();
      valid_e = 1; cond_e = 4'hE; flag_write_e = 2'b11;
      alu_flags = {4'(f), 1'b0};
      step();
      idle();
      for (int c = 0; c < 16; c++) begin
        cond_e = 4'(c);
        #1;
        check($sformatf("sweep_c%0h_f%0h", c, f), 32'(cond_ex), 32'(exp_cond(4'(c), 4'(f))));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
